// File: rtl/iv_bus_ctrl.sv
// IV-bus controller for the 8X305 core: bank address latches, combinational
// peripheral reads onto IV, and a posted-write FIFO shared with a host port.
module iv_bus_ctrl #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic               x1,
  input  logic               reset,
  input  logic [7:0]         iv_in,
  output logic [7:0]         iv_out,
  output logic               iv_oe,
  input  logic               lb_n,
  input  logic               rb_n,
  input  logic               sc,
  input  logic               wc,
  input  logic               mclk,
  output logic [7:0]         laddr,
  output logic [7:0]         raddr,
  input  logic [7:0]         lrd_data,
  input  logic [7:0]         rrd_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic               wr_bank,
  output logic [7:0]         wr_addr,
  output logic [7:0]         wr_data,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               host_bank,
  input  logic [7:0]         host_addr,
  input  logic [7:0]         host_data,
  input  logic               clr_status,
  output logic [DEPTH_W:0]   fifo_level,
  output logic               overflow,
  output logic               bank_err
);

  // IV pins are active-low and bit-reversed; the map is its own inverse.
  function automatic logic [7:0] iv_map(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = ~v[i];
    return r;
  endfunction

  logic [7:0]         laddr_q, laddr_d;
  logic [7:0]         raddr_q, raddr_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               bank_err_q, bank_err_d;
  logic [16:0]        mem_q [DEPTH];

  logic        capture, bank_ok, sel_right;
  logic [7:0]  iv_dec;
  logic        do_pop, space, cpu_push, host_push, push;
  logic [16:0] entry_d;

  always_comb begin
    capture   = mclk && (sc || wc);
    bank_ok   = lb_n ^ rb_n;
    sel_right = lb_n;
    iv_dec    = iv_map(iv_in);

    do_pop    = (level_q != '0) && wr_ready;
    space     = (level_q < (DEPTH_W+1)'(DEPTH)) || do_pop;
    // sc has priority over wc, so a combined strobe never writes.
    cpu_push  = capture && wc && !sc && bank_ok;
    host_ready = !cpu_push && space;
    host_push = host_valid && host_ready;
    push      = (cpu_push && space) || host_push;

    entry_d = {host_bank, host_addr, host_data};
    if (cpu_push) entry_d = {sel_right, (sel_right ? raddr_q : laddr_q), iv_dec};

    laddr_d = laddr_q;
    raddr_d = raddr_q;
    if (capture && sc && bank_ok) begin
      if (sel_right) raddr_d = iv_dec;
      else           laddr_d = iv_dec;
    end

    wr_ptr_d = wr_ptr_q + DEPTH_W'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_W'(do_pop);
    level_d  = level_q + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(do_pop);

    // A flag being set wins over a same-edge clear.
    overflow_d = clr_status ? 1'b0 : overflow_q;
    if (cpu_push && !space) overflow_d = 1'b1;
    bank_err_d = clr_status ? 1'b0 : bank_err_q;
    if (capture && !bank_ok) bank_err_d = 1'b1;
  end

  always_ff @(posedge x1) begin
    if (reset) begin
      laddr_q    <= '0;
      raddr_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      bank_err_q <= 1'b0;
    end else begin
      laddr_q    <= laddr_d;
      raddr_q    <= raddr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      bank_err_q <= bank_err_d;
    end
  end

  // Storage needs no reset: the level counter guards every read.
  always_ff @(posedge x1) begin
    if (!reset && push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign iv_oe      = !sc && !wc && bank_ok;
  assign iv_out     = iv_map(!lb_n ? lrd_data : rrd_data);
  assign laddr      = laddr_q;
  assign raddr      = raddr_q;
  assign wr_valid   = (level_q != '0);
  assign {wr_bank, wr_addr, wr_data} = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign bank_err   = bank_err_q;

endmodule
